rm_report_collector: RTL and testbench

Downstream stage of a runtime-monitor automaton cluster. It samples the automaton's report wires and tags each non-zero report vector with the index of the symbol that caused it. Tagged records are buffered in a small FIFO and drained through a valid/ready port toward the monitor's event/interrupt logic. It also provides sticky violation and overflow status so no report is lost silently.

---
 rtl/rm_report_collector.sv | 176 +++++++++++++++++
 tb/tb_rm_report_collector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rm_report_collector.sv
// rm_report_collector
// Samples the report vector of a runtime-monitor automaton. Each non-zero
// report is tagged with the index of the symbol that caused it. The tagged
// records are queued in a first-word-fall-through FIFO and leave through a
// valid/ready port. Sticky status flags and a saturating drop counter mean
// that a lost record is always visible.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   run_i               a symbol is presented this cycle
//   clear_i             synchronous flush of FIFO, counters and flags
//   report_i            automaton report states (one cycle behind the symbol)
//   rec_valid_o/ready_i record handshake
//   rec_report_o        report vector of the head record (0 when empty)
//   rec_index_o         symbol index of the head record (0 when empty)
//   count_o             FIFO occupancy
//   any_report_o        sticky: a report has been captured
//   overflow_o          sticky: a record has been dropped
//   drop_cnt_o          saturating count of dropped records
module rm_report_collector #(
    parameter int N_REPORTS = 4,
    parameter int IDX_W     = 32,
    parameter int DEPTH     = 8,
    parameter int DROP_W    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     run_i,
    input  logic                     clear_i,
    input  logic [N_REPORTS-1:0]     report_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [N_REPORTS-1:0]     rec_report_o,
    output logic [IDX_W-1:0]         rec_index_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     any_report_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]     sym_idx_q, sym_idx_d;
    logic                 run_q, run_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 any_q, any_d;
    logic                 ovf_q, ovf_d;
    logic [DROP_W-1:0]    drop_q, drop_d;
    logic [N_REPORTS-1:0] mem_rep_q [DEPTH];
    logic [IDX_W-1:0]     mem_idx_q [DEPTH];

    logic capture_s;
    logic pop_s;
    logic push_s;
    logic full_s;
    logic valid_s;

    assign valid_s   = (count_q != {CNT_W{1'b0}});
    assign full_s    = (count_q == CNT_W'(DEPTH));
    // Reports belong to the symbol of the previous cycle, so gate with run_q.
    assign capture_s = run_q && (|report_i);
    assign pop_s     = valid_s && rec_ready_i;
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign push_s    = capture_s && (!full_s || pop_s) && !clear_i;

    // Next-state logic for counters, pointers and status flags.
    always_comb begin
        sym_idx_d = sym_idx_q;
        run_d     = run_i;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        any_d     = any_q;
        ovf_d     = ovf_q;
        drop_d    = drop_q;
        if (clear_i) begin
            sym_idx_d = {IDX_W{1'b0}};
            run_d     = 1'b0;
            wr_ptr_d  = {PTR_W{1'b0}};
            rd_ptr_d  = {PTR_W{1'b0}};
            count_d   = {CNT_W{1'b0}};
            any_d     = 1'b0;
            ovf_d     = 1'b0;
            drop_d    = {DROP_W{1'b0}};
        end else begin
            if (run_i) begin
                sym_idx_d = sym_idx_q + IDX_W'(1);
            end else begin
                sym_idx_d = sym_idx_q;
            end
            if (capture_s) begin
                any_d = 1'b1;
            end else begin
                any_d = any_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (capture_s && !push_s) begin
                ovf_d = 1'b1;
                if (drop_q != {DROP_W{1'b1}}) begin
                    drop_d = drop_q + DROP_W'(1);
                end else begin
                    drop_d = drop_q;
                end
            end else begin
                ovf_d  = ovf_q;
                drop_d = drop_q;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sym_idx_q <= {IDX_W{1'b0}};
            run_q     <= 1'b0;
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            any_q     <= 1'b0;
            ovf_q     <= 1'b0;
            drop_q    <= {DROP_W{1'b0}};
        end else begin
            sym_idx_q <= sym_idx_d;
            run_q     <= run_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            any_q     <= any_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    // FIFO storage; the tag is the index of the previous symbol.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rep_q[i] <= {N_REPORTS{1'b0}};
                mem_idx_q[i] <= {IDX_W{1'b0}};
            end
        end else if (push_s) begin
            mem_rep_q[wr_ptr_q] <= report_i;
            mem_idx_q[wr_ptr_q] <= sym_idx_q - IDX_W'(1);
        end else begin
            mem_rep_q[wr_ptr_q] <= mem_rep_q[wr_ptr_q];
            mem_idx_q[wr_ptr_q] <= mem_idx_q[wr_ptr_q];
        end
    end

    // Outputs come straight from registers; the head reads as zero when empty.
    assign rec_valid_o  = valid_s;
    assign rec_report_o = valid_s ? mem_rep_q[rd_ptr_q] : {N_REPORTS{1'b0}};
    assign rec_index_o  = valid_s ? mem_idx_q[rd_ptr_q] : {IDX_W{1'b0}};
    assign count_o      = count_q;
    assign any_report_o = any_q;
    assign overflow_o   = ovf_q;
    assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_rm_report_collector.sv
module tb_rm_report_collector;

    localparam int NR    = 4;
    localparam int IW    = 4;
    localparam int DEP   = 8;
    localparam int DW    = 3;
    localparam int IMOD  = 16;
    localparam int DMAX  = 7;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          run_i;
    logic          clear_i;
    logic [NR-1:0] report_i;
    logic          rec_valid_o;
    logic          rec_ready_i;
    logic [NR-1:0] rec_report_o;
    logic [IW-1:0] rec_index_o;
    logic [3:0]    count_o;
    logic          any_report_o;
    logic          overflow_o;
    logic [DW-1:0] drop_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NR-1:0] rep;
        int            idx;
    } rec_t;

    rec_t m_q[$];
    int   m_sym;
    bit   m_run_prev;
    bit   m_any;
    bit   m_ovf;
    int   m_drop;

    rm_report_collector #(
        .N_REPORTS(NR), .IDX_W(IW), .DEPTH(DEP), .DROP_W(DW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .run_i(run_i), .clear_i(clear_i),
        .report_i(report_i), .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .rec_report_o(rec_report_o), .rec_index_o(rec_index_o), .count_o(count_o),
        .any_report_o(any_report_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_sym      = 0;
        m_run_prev = 1'b0;
        m_any      = 1'b0;
        m_ovf      = 1'b0;
        m_drop     = 0;
    endtask

    // One clock of the reference behaviour, evaluated on pre-edge state.
    task automatic model_update(input bit run, input logic [NR-1:0] rep, input bit rdy, input bit clr);
        bit   pop;
        bit   cap;
        rec_t r;
        pop = (m_q.size() != 0) && rdy;
        cap = m_run_prev && (rep != '0);
        if (clr) begin
            model_reset();
        end else begin
            r.rep = rep;
            r.idx = (m_sym + IMOD - 1) % IMOD;
            if (pop) void'(m_q.pop_front());
            if (cap) begin
                m_any = 1'b1;
                if (m_q.size() < DEP) m_q.push_back(r);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop < DMAX) m_drop++;
                end
            end
            m_sym      = (m_sym + int'(run)) % IMOD;
            m_run_prev = run;
        end
    endtask

    task automatic check_all();
        chk("rec_valid", {31'd0, rec_valid_o}, {31'd0, m_q.size() != 0});
        chk("rec_report", {28'd0, rec_report_o}, (m_q.size() != 0) ? {28'd0, m_q[0].rep} : 32'd0);
        chk("rec_index", {28'd0, rec_index_o}, (m_q.size() != 0) ? m_q[0].idx : 32'd0);
        chk("count", {28'd0, count_o}, m_q.size());
        chk("any_report", {31'd0, any_report_o}, {31'd0, m_any});
        chk("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
        chk("drop_cnt", {29'd0, drop_cnt_o}, m_drop);
    endtask

    task automatic step(input bit run, input logic [NR-1:0] rep, input bit rdy, input bit clr);
        run_i       = run;
        report_i    = rep;
        rec_ready_i = rdy;
        clear_i     = clr;
        model_update(run, rep, rdy, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_valid"}, {31'd0, rec_valid_o}, 32'd0);
        chk({tag, "_report"}, {28'd0, rec_report_o}, 32'd0);
        chk({tag, "_index"}, {28'd0, rec_index_o}, 32'd0);
        chk({tag, "_count"}, {28'd0, count_o}, 32'd0);
        chk({tag, "_any"}, {31'd0, any_report_o}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, overflow_o}, 32'd0);
        chk({tag, "_drop"}, {29'd0, drop_cnt_o}, 32'd0);
    endtask

    // Reset pulse that starts and ends between clock edges.
    task automatic reset_pulse(input string tag);
        #2;
        rst_ni = 1'b0;
        #1;
        zero_check(tag);
        model_reset();
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        run_i       = 1'b0;
        clear_i     = 1'b0;
        report_i    = '0;
        rec_ready_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        zero_check("reset");
        rst_ni = 1'b1;

        // Single report on symbol 3.
        for (int k = 0; k <= 5; k++) begin
            step(1'b1, (k == 4) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
            if (k == 4) begin
                chk("single_valid", {31'd0, rec_valid_o}, 32'd1);
                chk("single_index", {28'd0, rec_index_o}, 32'd3);
                chk("single_report", {28'd0, rec_report_o}, 32'h4);
            end
        end
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        chk("single_drained", {28'd0, count_o}, 32'd0);
        chk("single_any", {31'd0, any_report_o}, 32'd1);
        step(1'b0, 4'b0000, 1'b0, 1'b1);

        // Back-pressure: captures for symbols 1, 2, 3 then drain.
        for (int s = 0; s <= 4; s++)
            step(1'b1, (s >= 2) ? 4'(s + 1) : 4'b0000, 1'b0, 1'b0);
        chk("bp_count", {28'd0, count_o}, 32'd3);
        chk("bp_head", {28'd0, rec_index_o}, 32'd1);
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        chk("bp_hold", {28'd0, rec_index_o}, 32'd1);
        for (int s = 2; s <= 4; s++) begin
            step(1'b0, 4'b0000, 1'b1, 1'b0);
            chk("bp_order", {28'd0, rec_index_o}, (s <= 3) ? s : 32'd0);
        end
        step(1'b0, 4'b0000, 1'b0, 1'b1);

        // Fill to full, push+pop while full, then overflow.
        for (int s = 0; s <= 8; s++)
            step(1'b1, (s >= 1) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
        chk("full_count", {28'd0, count_o}, 32'd8);
        step(1'b1, 4'b0001, 1'b1, 1'b0);
        chk("full_pp_count", {28'd0, count_o}, 32'd8);
        chk("full_pp_ovf", {31'd0, overflow_o}, 32'd0);
        for (int s = 10; s <= 12; s++)
            step(1'b1, 4'b0010, 1'b0, 1'b0);
        chk("ovf_flag", {31'd0, overflow_o}, 32'd1);
        chk("ovf_drop", {29'd0, drop_cnt_o}, 32'd3);
        for (int s = 0; s < 8; s++)
            step(1'b0, 4'b0000, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 1'b1);

        // Gating and index wrap.
        for (int s = 0; s <= 16; s++) begin
            step(1'b1, 4'b1111, 1'b1, 1'b0);
            step(1'b0, (s == 16) ? 4'b0110 : 4'b0000, 1'b1, 1'b0);
            if (s == 15) chk("gate_none", {31'd0, any_report_o}, 32'd0);
        end
        chk("wrap_index", {28'd0, rec_index_o}, 32'd0);
        chk("wrap_valid", {31'd0, rec_valid_o}, 32'd1);
        step(1'b0, 4'b0000, 1'b0, 1'b1);

        // Clear with coincident capture.
        for (int s = 0; s <= 9; s++)
            step(1'b1, (s >= 1) ? 4'b0101 : 4'b0000, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++)
            step(1'b0, 4'b0000, 1'b1, 1'b0);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("pre_clear_count", {28'd0, count_o}, 32'd5);
        step(1'b0, 4'b1010, 1'b1, 1'b1);
        zero_check("clear");

        // Asynchronous reset mid-stream.
        for (int s = 0; s <= 4; s++)
            step(1'b1, (s >= 1) ? 4'b0011 : 4'b0000, 1'b0, 1'b0);
        reset_pulse("arst");
        step(1'b1, 4'b1111, 1'b1, 1'b0);
        chk("arst_no_partial", {31'd0, rec_valid_o}, 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            bit rdy;
            rdy = ((i % 100) < 50) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom),
                 rdy,
                 $urandom_range(0, 99) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
